// File: rtl/uart_frame_tx.sv
// Framed UART transmitter: header, addr, mode, payload, optional checksum.
// One trigger edge produces one frame; edges seen while busy are reported.
module uart_frame_tx #(
  parameter int unsigned BPS_CNT    = 434,
  parameter int unsigned DATA_BYTES = 3,
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int unsigned CHK_EN     = 1,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned GAP_BITS   = 0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    trig,
  input  logic [1:0]              addr,
  input  logic [5:0]              mod_sel,
  input  logic [8*DATA_BYTES-1:0] data,
  output logic                    uart_txd,
  output logic                    busy,
  output logic                    done,
  output logic                    trig_lost
);

  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int unsigned FL = 3 + DATA_BYTES + CHK_EN;

  localparam logic [15:0] CNT_LAST  = 16'(BPS_CNT - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [3:0]  GAP_LAST  =
    (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;
  localparam logic [4:0]  IDX_LAST  = 5'(FL - 1);
  localparam logic [4:0]  SUM_LAST  = 5'(2 + DATA_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_BITS,
    S_STOP,
    S_GAP,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic          sync1_q, sync2_q, hist_q, edge_q;
  logic [15:0]   cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [4:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    chk_q, chk_d;
  logic [1:0]    addr_q, addr_d;
  logic [5:0]    mod_q, mod_d;
  logic [DW-1:0] data_q, data_d;
  logic [7:0]    byte_sel;
  logic          tick;
  logic          seg_last;
  logic          take;

  assign tick = (cnt_q == CNT_LAST);
  assign take = (state_q == S_IDLE) && edge_q;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      edge_q  <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      chk_q   <= '0;
      addr_q  <= '0;
      mod_q   <= '0;
      data_q  <= '0;
    end else begin
      sync1_q <= trig;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      edge_q  <= sync2_q & ~hist_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      chk_q   <= chk_d;
      addr_q  <= addr_d;
      mod_q   <= mod_d;
      data_q  <= data_d;
    end
  end

  // Last bit period of the current segment (data, stop or gap).
  always_comb begin
    seg_last = 1'b0;
    unique case (state_q)
      S_BITS:  seg_last = (bit_q == 4'd7);
      S_STOP:  seg_last = (bit_q == STOP_LAST);
      S_GAP:   seg_last = (bit_q == GAP_LAST);
      default: seg_last = 1'b0;
    endcase
  end

  always_comb begin
    byte_sel = chk_q;
    if (idx_q == 5'd0) byte_sel = HEADER;
    if (idx_q == 5'd1) byte_sel = {6'b0, addr_q};
    if (idx_q == 5'd2) byte_sel = {2'b0, mod_q};
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (idx_q == 5'(3 + i))
        byte_sel = data_q[8*(DATA_BYTES-1-i) +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (edge_q) state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: if (tick) state_d = S_BITS;
      S_BITS:  if (tick && seg_last) state_d = S_STOP;
      S_STOP: begin
        if (tick && seg_last) begin
          if (idx_q != IDX_LAST)
            state_d = (GAP_BITS > 0) ? S_GAP : S_LOAD;
          else
            state_d = S_DONE;
        end
      end
      S_GAP:   if (tick && seg_last) state_d = S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = '0;
    bit_d  = bit_q;
    idx_d  = idx_q;
    sh_d   = sh_q;
    chk_d  = chk_q;
    addr_d = addr_q;
    mod_d  = mod_q;
    data_d = data_q;
    if (take) begin
      addr_d = addr;
      mod_d  = mod_sel;
      data_d = data;
      idx_d  = '0;
      chk_d  = '0;
      bit_d  = '0;
    end
    unique case (state_q)
      S_LOAD: begin
        sh_d  = byte_sel;
        bit_d = '0;
        if (idx_q != 5'd0 && idx_q <= SUM_LAST)
          chk_d = chk_q + byte_sel;
      end
      S_START, S_BITS, S_STOP, S_GAP: begin
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
        if (tick && state_q != S_START)
          bit_d = seg_last ? 4'd0 : bit_q + 4'd1;
        if (tick && state_q == S_BITS)
          sh_d = {1'b0, sh_q[7:1]};
        if (tick && seg_last && state_q == S_STOP
            && idx_q != IDX_LAST)
          idx_d = idx_q + 5'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    uart_txd  = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    trig_lost = edge_q && (state_q != S_IDLE);
    unique case (state_q)
      S_START: begin
        uart_txd = 1'b0;
        busy     = 1'b1;
      end
      S_BITS: begin
        uart_txd = sh_q[0];
        busy     = 1'b1;
      end
      S_LOAD, S_STOP, S_GAP: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: two configurations driven in parallel and
// compared every cycle against a frame-level waveform model.
module tb_uart_frame_tx;

  localparam int B = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic [1:0]  addr;
  logic [5:0]  mod_sel;
  logic [23:0] data;
  logic [1:0]  txd, busy, done, lost;

  always #5 clk = ~clk;

  uart_frame_tx #(
    .BPS_CNT(B), .DATA_BYTES(3), .HEADER(8'hA5),
    .CHK_EN(1), .STOP_BITS(1), .GAP_BITS(0)
  ) u_a (
    .sys_clk(clk), .sys_rst(rst), .trig(trig),
    .addr(addr), .mod_sel(mod_sel), .data(data),
    .uart_txd(txd[0]), .busy(busy[0]),
    .done(done[0]), .trig_lost(lost[0])
  );

  uart_frame_tx #(
    .BPS_CNT(B), .DATA_BYTES(3), .HEADER(8'hA5),
    .CHK_EN(0), .STOP_BITS(2), .GAP_BITS(1)
  ) u_b (
    .sys_clk(clk), .sys_rst(rst), .trig(trig),
    .addr(addr), .mod_sel(mod_sel), .data(data),
    .uart_txd(txd[1]), .busy(busy[1]),
    .done(done[1]), .trig_lost(lost[1])
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int sbv[2] = '{1, 2};
  int gapv[2] = '{0, 1};
  int chkv[2] = '{1, 0};

  logic [2:0] expq [2][$];
  int         edgeq[$];
  logic       prev_trig = 1'b0;
  logic [7:0] rxq [2][$];
  int         blen[2];
  int         dcnt[2];
  int         lcnt[2];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Expected {txd,busy,done} per cycle from the LOAD cycle to done.
  function automatic void build(input int d, input logic [1:0] a,
                                input logic [5:0] m,
                                input logic [23:0] dt);
    logic [7:0] by[$];
    logic [7:0] s;
    by.push_back(8'hA5);
    by.push_back({6'b0, a});
    by.push_back({2'b0, m});
    by.push_back(dt[23:16]);
    by.push_back(dt[15:8]);
    by.push_back(dt[7:0]);
    s = 8'h00;
    for (int i = 1; i < 6; i++) s = s + by[i];
    if (chkv[d] != 0) by.push_back(s);
    for (int i = 0; i < by.size(); i++) begin
      expq[d].push_back(3'b110);
      repeat (B) expq[d].push_back(3'b010);
      for (int j = 0; j < 8; j++)
        repeat (B) expq[d].push_back({by[i][j], 2'b10});
      repeat (sbv[d] * B) expq[d].push_back(3'b110);
      if (i != by.size() - 1)
        repeat (gapv[d] * B) expq[d].push_back(3'b110);
    end
    expq[d].push_back(3'b101);
  endfunction

  // Model: a trig sample rising at edge p makes cycle p+2 the decision
  // cycle; an idle block starts LOAD at p+3, start bit at p+4.
  initial begin
    logic [2:0] e;
    logic       le, ev, idle;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        expq[0].delete();
        expq[1].delete();
        edgeq.delete();
        prev_trig = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
        e  = (expq[d].size() > 0) ? expq[d][0] : 3'b100;
        le = (edgeq.size() > 0) && (edgeq[0] == cyc)
             && (expq[d].size() > 0);
        chk($sformatf("cyc%0d dut%0d txd_busy_done_lost", cyc, d),
            {60'd0, txd[d], busy[d], done[d], lost[d]},
            {60'd0, e, le});
      end
      @(posedge clk);
      if (rst) begin
        ev = (edgeq.size() > 0) && (edgeq[0] == cyc);
        if (ev) void'(edgeq.pop_front());
        for (int d = 0; d < 2; d++) begin
          idle = (expq[d].size() == 0);
          if (!idle) void'(expq[d].pop_front());
          if (ev && idle) build(d, addr, mod_sel, data);
        end
        cyc++;
        if (trig && !prev_trig) edgeq.push_back(cyc + 2);
        prev_trig = trig;
      end else begin
        cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (busy[d]) blen[d]++;
        if (done[d]) dcnt[d]++;
        if (lost[d]) lcnt[d]++;
      end
    end
  end

  task automatic rx(input int d);
    logic [7:0] b;
    forever begin
      @(negedge clk);
      #1;
      if (txd[d] === 1'b0) begin
        repeat (B / 2) begin @(negedge clk); #1; end
        for (int j = 0; j < 8; j++) begin
          repeat (B) begin @(negedge clk); #1; end
          b[j] = txd[d];
        end
        repeat (B) begin @(negedge clk); #1; end
        rxq[d].push_back(b);
      end
    end
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      rxq[d].delete();
      blen[d] = 0;
      dcnt[d] = 0;
      lcnt[d] = 0;
    end
  endtask

  task automatic fire(input logic [1:0] a, input logic [5:0] m,
                      input logic [23:0] dt, input int w);
    addr = a;
    mod_sel = m;
    data = dt;
    clr();
    trig = 1'b1;
    repeat (w) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (6) @(negedge clk);
    while (busy != 2'b00 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(n >= 3000), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input int d, input int n,
                             input logic [63:0] v);
    logic [63:0] g;
    chk($sformatf("dut%0d nbytes", d), 64'(rxq[d].size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      g = 64'hFFFF;
      if (i < rxq[d].size()) g = {56'd0, rxq[d][i]};
      chk($sformatf("dut%0d byte%0d", d, i), g,
          {56'd0, v[8*(n-1-i) +: 8]});
    end
  endtask

  initial begin
    int k;
    rst = 1'b0;
    trig = 1'b0;
    addr = '0;
    mod_sel = '0;
    data = '0;
    fork
      rx(0);
      rx(1);
    join_none
    repeat (3) @(negedge clk);
    chk("reset_outs", {56'd0, txd, busy, done, lost}, 64'hC0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    addr = 2'd2;
    mod_sel = 6'h15;
    data = 24'h123456;
    clr();
    trig = 1'b1;
    k = 0;
    while (txd[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("start_latency", 64'(k), 64'd5);
    trig = 1'b0;
    wait_idle();
    check_frame(0, 7, 64'hA5021512_3456B3);
    check_frame(1, 6, 64'hA502_15123456);
    chk("dut0 done", 64'(dcnt[0]), 64'd1);
    chk("dut1 done", 64'(dcnt[1]), 64'd1);
    chk("dut0 busy_len", 64'(blen[0]), 64'd287);
    chk("dut1 busy_len", 64'(blen[1]), 64'd290);
    chk("dut0 idle_lost", 64'(lcnt[0]), 64'd0);

    fire(2'd3, 6'h3F, 24'hFFFFFF, 1);
    wait_idle();
    check_frame(0, 7, 64'hA5033FFF_FFFF3F);
    check_frame(1, 6, 64'hA5033F_FFFFFF);

    addr = 2'd1;
    mod_sel = 6'h2A;
    data = 24'hABCDEF;
    clr();
    trig = 1'b1;
    repeat (4) @(negedge clk);
    data = 24'(($urandom));
    addr = 2'($urandom_range(0, 3));
    mod_sel = 6'($urandom_range(0, 63));
    repeat (996) @(negedge clk);
    trig = 1'b0;
    wait_idle();
    chk("hold dut0 done", 64'(dcnt[0]), 64'd1);
    chk("hold dut1 done", 64'(dcnt[1]), 64'd1);
    check_frame(0, 7, 64'hA5012AAB_CDEF92);
    check_frame(1, 6, 64'hA5012A_ABCDEF);

    fire(2'd0, 6'h3C, 24'h010203, 2);
    repeat (100) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_idle();
    chk("dut0 lost", 64'(lcnt[0]), 64'd1);
    chk("dut1 lost", 64'(lcnt[1]), 64'd1);
    chk("dut0 done2", 64'(dcnt[0]), 64'd1);
    check_frame(0, 7, 64'hA5003C01_020342);
    check_frame(1, 6, 64'hA5003C_010203);

    fire(2'd2, 6'h15, 24'h123456, 1);
    k = 0;
    while (rxq[0].size() < 4 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("reach_byte34", 64'(k >= 2000), 64'd0);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort txd", {62'd0, txd}, 64'd3);
    chk("abort busy", {62'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    fire(2'd2, 6'h15, 24'h123456, 1);
    wait_idle();
    check_frame(0, 7, 64'hA5021512_3456B3);
    check_frame(1, 6, 64'hA502_15123456);

    for (int it = 0; it < 8; it++) begin
      fire(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
           24'($urandom), $urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(20, 200)) @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
      end
      wait_idle();
      chk($sformatf("rand%0d dut0 done", it), 64'(dcnt[0]), 64'd1);
      chk($sformatf("rand%0d dut1 done", it), 64'(dcnt[1]), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", errs);
    $fatal(1);
  end

endmodule
